// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART memory loader.
// Contents: framing byte codes, payload decode widths, writer state encoding,
// and the decoded address/data word passed from the parser to the writer.
package loader_pkg;

  localparam logic [7:0] START_BYTE    = 8'hF5;
  localparam logic [7:0] STOP_BYTE     = 8'hFA;
  localparam logic [7:0] READ_OUT_BYTE = 8'hF6;

  localparam int unsigned ADDR_HALF_W   = 5;
  localparam int unsigned DATA_HALF_W   = 6;
  localparam int unsigned PAYLOAD_BYTES = 4;
  localparam int unsigned WORD_ADDR_W   = 2 * ADDR_HALF_W;
  localparam int unsigned WORD_DATA_W   = 2 * DATA_HALF_W;

  typedef enum logic [2:0] {
    CLEAR_A,
    CLEAR_DL,
    CLEAR_DU,
    IDLE,
    W_ADDR,
    W_DL,
    W_DU
  } wr_state_t;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] addr;
    logic [WORD_DATA_W-1:0] data;
  } mem_word_t;

endpackage

// File: rtl/uart_mem_loader_if.sv
// Byte-in / memory-bus-out signal bundle of the loader.
// master: loader side (consumes rx bytes, drives the memory bus).
// slave : environment side (uart_rx + memory mux).
interface uart_mem_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] mem_addr_data;
  logic              mem_read_write;
  logic              mem_write_commit;
  logic              mem_own;

  modport master (
    input  rx_data, rx_valid,
    output mem_addr_data, mem_read_write, mem_write_commit, mem_own
  );

  modport slave (
    output rx_data, rx_valid,
    input  mem_addr_data, mem_read_write, mem_write_commit, mem_own
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Host byte-stream parser: START, 4 payload bytes, STOP -> one decoded word.
// Ports: clk, rst_n; rx_data/rx_valid byte strobe in;
//        commit_c/word_c (combinational, valid in the STOP byte cycle);
//        frame_err (registered, sticky until next START); dump_req (one-cycle pulse).
module uart_frame_parser
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       commit_c,
  output mem_word_t  word_c,
  output logic       frame_err,
  output logic       dump_req
);

  logic                   in_frame;
  logic [2:0]             count;
  logic [ADDR_HALF_W-1:0] b0, b1;
  logic [DATA_HALF_W-1:0] b2, b3;

  // Only the low payload bits are ever kept, so decode is a plain concatenation.
  assign commit_c    = rx_valid && in_frame && (rx_data == STOP_BYTE)
                       && (count == 3'(PAYLOAD_BYTES));
  assign word_c.addr = {b0, b1};
  assign word_c.data = {b2, b3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame  <= 1'b0;
      count     <= '0;
      b0        <= '0;
      b1        <= '0;
      b2        <= '0;
      b3        <= '0;
      frame_err <= 1'b0;
      dump_req  <= 1'b0;
    end else begin
      dump_req <= rx_valid && (rx_data == READ_OUT_BYTE);
      if (rx_valid) begin
        if (rx_data == START_BYTE) begin
          in_frame  <= 1'b1;
          count     <= '0;
          frame_err <= 1'b0;
        end else if (rx_data == READ_OUT_BYTE) begin
          // Dump requests are transparent to framing.
          in_frame <= in_frame;
        end else if (in_frame) begin
          if (rx_data == STOP_BYTE) begin
            in_frame <= 1'b0;
            if (count != 3'(PAYLOAD_BYTES)) frame_err <= 1'b1;
          end else if (count == 3'(PAYLOAD_BYTES)) begin
            // Too many payload bytes: drop the frame until the next START.
            in_frame  <= 1'b0;
            frame_err <= 1'b1;
          end else begin
            case (count)
              3'd0:    b0 <= rx_data[ADDR_HALF_W-1:0];
              3'd1:    b1 <= rx_data[ADDR_HALF_W-1:0];
              3'd2:    b2 <= rx_data[DATA_HALF_W-1:0];
              default: b3 <= rx_data[DATA_HALF_W-1:0];
            endcase
            count <= count + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// UART-to-memory loader: parses host frames, buffers one decoded word in a
// pending slot and writes it through the 3-cycle memory write protocol while
// holding mem_own. Optionally sweeps the whole memory to zero after reset.
// Ports: clk, rst_n; bus (rx byte in, memory bus out);
//        dump_req, busy, frame_err, overrun, words_written status outputs.
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DATA_W         = 12,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_mem_loader_if.master   bus,
  output logic                dump_req,
  output logic                busy,
  output logic                frame_err,
  output logic                overrun,
  output logic [15:0]         words_written
);

  logic      commit_c;
  mem_word_t word_c;

  uart_frame_parser u_parser (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (bus.rx_data),
    .rx_valid  (bus.rx_valid),
    .commit_c  (commit_c),
    .word_c    (word_c),
    .frame_err (frame_err),
    .dump_req  (dump_req)
  );

  wr_state_t         state, state_n;
  logic              sweep_req, sweep_req_n;
  logic [ADDR_W-1:0] clr_addr, clr_addr_n;
  logic [DATA_W-1:0] wr_data, wr_data_n;
  logic              pend_full, pend_full_n, pend_take;
  mem_word_t         pend, pend_n;
  logic              own_n, rw_n, commit_n, busy_n, overrun_n;
  logic [ADDR_W-1:0] bus_n;
  logic [15:0]       words_n;

  // Next state plus the bus values of that next state, so every output is a flop.
  always_comb begin
    state_n     = state;
    sweep_req_n = sweep_req;
    clr_addr_n  = clr_addr;
    wr_data_n   = wr_data;
    words_n     = words_written;
    pend_take   = 1'b0;
    own_n       = 1'b1;
    rw_n        = 1'b0;
    commit_n    = 1'b0;
    bus_n       = '0;

    case (state)
      IDLE: begin
        own_n = 1'b0;
        if (sweep_req) begin
          state_n     = CLEAR_A;
          sweep_req_n = 1'b0;
          clr_addr_n  = '0;
          own_n       = 1'b1;
          rw_n        = 1'b1;
        end else if (pend_full) begin
          state_n   = W_ADDR;
          pend_take = 1'b1;
          wr_data_n = DATA_W'(pend.data);
          own_n     = 1'b1;
          rw_n      = 1'b1;
          bus_n     = ADDR_W'(pend.addr);
        end
      end
      CLEAR_A: begin
        state_n = CLEAR_DL;
        rw_n    = 1'b1;
      end
      CLEAR_DL: begin
        state_n  = CLEAR_DU;
        commit_n = 1'b1;
      end
      CLEAR_DU: begin
        if (clr_addr == ADDR_W'(DEPTH - 1)) begin
          state_n = IDLE;
          own_n   = 1'b0;
        end else begin
          state_n    = CLEAR_A;
          clr_addr_n = clr_addr + ADDR_W'(1);
          rw_n       = 1'b1;
          bus_n      = clr_addr + ADDR_W'(1);
        end
      end
      W_ADDR: begin
        state_n = W_DL;
        rw_n    = 1'b1;
        bus_n   = ADDR_W'(wr_data[DATA_HALF_W-1:0]);
      end
      W_DL: begin
        state_n  = W_DU;
        commit_n = 1'b1;
        bus_n    = ADDR_W'(wr_data[DATA_W-1:DATA_HALF_W]);
      end
      W_DU: begin
        state_n = IDLE;
        own_n   = 1'b0;
        words_n = words_written + 16'd1;
      end
      default: begin
        state_n = IDLE;
        own_n   = 1'b0;
      end
    endcase

    // Pending slot: a commit may refill the slot on the same edge it drains.
    pend_n      = pend;
    pend_full_n = pend_full && !pend_take;
    overrun_n   = overrun;
    if (commit_c) begin
      if (!pend_full || pend_take) begin
        pend_n      = word_c;
        pend_full_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end

    busy_n = (state_n != IDLE) || pend_full_n;
  end

  // The sweep request is armed by reset so the first edge after release enters CLEAR_A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      sweep_req            <= (CLEAR_ON_RESET != 0);
      clr_addr             <= '0;
      wr_data              <= '0;
      pend_full            <= 1'b0;
      pend                 <= '0;
      overrun              <= 1'b0;
      busy                 <= 1'b0;
      words_written        <= '0;
      bus.mem_own          <= 1'b0;
      bus.mem_read_write   <= 1'b0;
      bus.mem_write_commit <= 1'b0;
      bus.mem_addr_data    <= '0;
    end else begin
      state                <= state_n;
      sweep_req            <= sweep_req_n;
      clr_addr             <= clr_addr_n;
      wr_data              <= wr_data_n;
      pend_full            <= pend_full_n;
      pend                 <= pend_n;
      overrun              <= overrun_n;
      busy                 <= busy_n;
      words_written        <= words_n;
      bus.mem_own          <= own_n;
      bus.mem_read_write   <= rw_n;
      bus.mem_write_commit <= commit_n;
      bus.mem_addr_data    <= bus_n;
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: dut0 without the clear sweep, dut1 with it.
// Frames sent to dut0 are mirrored by a frame-level reference model.
module tb_uart_mem_loader;
  import loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  uart_mem_loader_if if0 ();
  uart_mem_loader_if if1 ();

  logic        dump0, busy0, ferr0, ovr0;
  logic        dump1, busy1, ferr1, ovr1;
  logic [15:0] words0, words1;

  uart_mem_loader #(.CLEAR_ON_RESET(0)) dut0 (
    .clk(clk), .rst_n(rst0), .bus(if0), .dump_req(dump0), .busy(busy0),
    .frame_err(ferr0), .overrun(ovr0), .words_written(words0)
  );

  uart_mem_loader #(.CLEAR_ON_RESET(1), .DEPTH(1024)) dut1 (
    .clk(clk), .rst_n(rst1), .bus(if1), .dump_req(dump1), .busy(busy1),
    .frame_err(ferr1), .overrun(ovr1), .words_written(words1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Frame-level reference model for dut0.
  bit        m_in_frame = 0;
  int        m_bytes[$];
  bit        m_err = 0;
  int        m_dumps = 0;
  int        m_writes = 0;
  mem_word_t exp_q[$];

  function void model_byte(input int b);
    int a, d;
    if (b == 'hF5) begin
      m_in_frame = 1;
      m_bytes.delete();
      m_err = 0;
    end else if (b == 'hF6) begin
      m_dumps++;
    end else if (m_in_frame) begin
      if (b == 'hFA) begin
        if (m_bytes.size() == 4) begin
          a = (m_bytes[0] % 32) * 32 + (m_bytes[1] % 32);
          d = (m_bytes[2] % 64) * 64 + (m_bytes[3] % 64);
          exp_q.push_back('{addr: 10'(a), data: 12'(d)});
          m_writes++;
        end else begin
          m_err = 1;
        end
        m_in_frame = 0;
      end else if (m_bytes.size() == 4) begin
        m_err = 1;
        m_in_frame = 0;
      end else begin
        m_bytes.push_back(b);
      end
    end
  endfunction

  // Bus monitors: a write is the (addr, data-low, data-high) triple ending on commit.
  mem_word_t   obs0_q[$], obs1_q[$];
  int          dumps0 = 0;
  logic [9:0]  p1_0 = '0, p2_0 = '0, p1_1 = '0, p2_1 = '0;
  int          c1 = 0, own_cnt1 = 0, own_rise1 = 0, commits1 = 0, sweep_bad = 0;
  logic        prev_own1 = 1'b0;
  logic [9:0]  last_sweep = '0;

  always @(negedge clk) begin
    if (if0.mem_write_commit)
      obs0_q.push_back('{addr: p2_0, data: {if0.mem_addr_data[5:0], p1_0[5:0]}});
    if (dump0) dumps0 <= dumps0 + 1;
    p2_0 <= p1_0;
    p1_0 <= if0.mem_addr_data;
  end

  always @(negedge clk) begin
    if (!rst1) begin
      c1        <= 0;
      own_cnt1  <= 0;
      own_rise1 <= 0;
      prev_own1 <= 1'b0;
    end else begin
      if (if1.mem_write_commit) begin
        commits1 <= commits1 + 1;
        if (c1 < 1024) begin
          if (p2_1 != 10'(c1) || p1_1 != 10'd0 || if1.mem_addr_data != 10'd0)
            sweep_bad <= sweep_bad + 1;
          last_sweep <= p2_1;
        end else begin
          obs1_q.push_back('{addr: p2_1, data: {if1.mem_addr_data[5:0], p1_1[5:0]}});
        end
        c1 <= c1 + 1;
      end
      if (if1.mem_own) own_cnt1 <= own_cnt1 + 1;
      if (if1.mem_own && !prev_own1) own_rise1 <= own_rise1 + 1;
      prev_own1 <= if1.mem_own;
    end
    p2_1 <= p1_1;
    p1_1 <= if1.mem_addr_data;
  end

  task automatic send(input int sel, input int b, input int max_gap);
    repeat ($urandom_range(0, max_gap)) @(posedge clk);
    @(posedge clk);
    #1;
    if (sel == 0) begin
      if0.rx_data  = 8'(b);
      if0.rx_valid = 1'b1;
      model_byte(b);
    end else begin
      if1.rx_data  = 8'(b);
      if1.rx_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if0.rx_valid = 1'b0;
    if1.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int sel, input int a0, input int a1, input int a2, input int a3);
    send(sel, 'hF5, 0);
    send(sel, a0, 0);
    send(sel, a1, 0);
    send(sel, a2, 0);
    send(sel, a3, 0);
    send(sel, 'hFA, 0);
  endtask

  task automatic compare_writes(input string tag);
    check_val({tag, "_nwrites"}, 32'(obs0_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs0_q.size(); i++) begin
      check_val({tag, "_addr"}, 32'(obs0_q[i].addr), 32'(exp_q[i].addr));
      check_val({tag, "_data"}, 32'(obs0_q[i].data), 32'(exp_q[i].data));
    end
    obs0_q.delete();
    exp_q.delete();
  endtask

  task automatic check_model(input string tag);
    repeat (8) @(posedge clk);
    #1;
    compare_writes(tag);
    check_val({tag, "_ferr"}, 32'(ferr0), 32'(m_err));
    check_val({tag, "_dumps"}, 32'(dumps0), 32'(m_dumps));
    check_val({tag, "_words"}, 32'(words0), 32'(16'(m_writes)));
  endtask

  task automatic wait_idle1(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (busy1 && k < 8000) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_idle_timeout"}, 32'(busy1), 32'd0);
  endtask

  task automatic wait_own1(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!if1.mem_own && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_own_timeout"}, 32'(if1.mem_own), 32'd1);
  endtask

  initial begin
    int kind, n, pos, commits_before;
    rst0 = 1'b0;
    rst1 = 1'b0;
    if0.rx_data = '0; if0.rx_valid = 1'b0;
    if1.rx_data = '0; if1.rx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_ctl0", 32'({if0.mem_own, if0.mem_read_write, if0.mem_write_commit,
                                busy0, ferr0, ovr0, dump0}), 32'd0);
    check_val("rst_bus0", 32'(if0.mem_addr_data), 32'd0);
    check_val("rst_words0", 32'(words0), 32'd0);
    check_val("rst_ctl1", 32'({if1.mem_own, if1.mem_read_write, if1.mem_write_commit,
                                busy1, ferr1, ovr1, dump1}), 32'd0);
    @(posedge clk);
    #1;
    rst0 = 1'b1;
    rst1 = 1'b1;

    // Directed write with exact bus timing
    send_frame(0, 'h01, 'h02, 'h03, 'h04);
    @(negedge clk);
    check_val("t1_n1_own", 32'(if0.mem_own), 32'd0);
    check_val("t1_n1_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    check_val("t1_addr_phase", 32'({if0.mem_own, if0.mem_read_write, if0.mem_write_commit,
                                     if0.mem_addr_data}), 32'({3'b110, 10'h022}));
    @(negedge clk);
    check_val("t1_dl_phase", 32'({if0.mem_own, if0.mem_read_write, if0.mem_write_commit,
                                   if0.mem_addr_data}), 32'({3'b110, 10'h004}));
    @(negedge clk);
    check_val("t1_du_phase", 32'({if0.mem_own, if0.mem_read_write, if0.mem_write_commit,
                                   if0.mem_addr_data}), 32'({3'b101, 10'h003}));
    @(negedge clk);
    check_val("t1_release", 32'({if0.mem_own, if0.mem_write_commit, busy0}), 32'd0);
    check_model("t1");

    // Short frame flags frame_err without a write; START clears it
    send(0, 'hF5, 0); send(0, 'h01, 0); send(0, 'h02, 0); send(0, 'hFA, 0);
    check_model("t2");
    check_val("t2_ferr_set", 32'(ferr0), 32'd1);
    send(0, 'hF5, 0);
    @(negedge clk);
    check_val("t2_ferr_clr", 32'(ferr0), 32'd0);
    send(0, 'h11, 0); send(0, 'h12, 0); send(0, 'h13, 0); send(0, 'h14, 0); send(0, 'hFA, 0);
    check_model("t2b");

    // READ_OUT inside a frame
    send(0, 'hF5, 0); send(0, 'h01, 0); send(0, 'hF6, 0); send(0, 'h02, 0);
    send(0, 'h03, 0); send(0, 'h04, 0); send(0, 'hFA, 0);
    repeat (8) @(posedge clk);
    #1;
    check_val("t4_addr", 32'(obs0_q.size() > 0 ? obs0_q[0].addr : 10'h3FF), 32'h022);
    check_val("t4_data", 32'(obs0_q.size() > 0 ? obs0_q[0].data : 12'hFFF), 32'h0C4);
    check_model("t4");

    // Randomized frames against the model
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          send(0, 'hF5, 2);
          for (int j = 0; j < 4; j++) send(0, $urandom_range(0, 'hF4), 2);
          send(0, 'hFA, 2);
        end
        1: begin
          n = $urandom_range(0, 3);
          send(0, 'hF5, 2);
          for (int j = 0; j < n; j++) send(0, $urandom_range(0, 'hF4), 2);
          send(0, 'hFA, 2);
        end
        2: begin
          send(0, 'hF5, 2);
          for (int j = 0; j < 5; j++) send(0, $urandom_range(0, 'hF4), 2);
          send(0, 'hFA, 2);
        end
        3: begin
          pos = $urandom_range(0, 4);
          send(0, 'hF5, 2);
          for (int j = 0; j < 4; j++) begin
            if (j == pos) send(0, 'hF6, 2);
            send(0, $urandom_range(0, 'hF4), 2);
          end
          if (pos == 4) send(0, 'hF6, 2);
          send(0, 'hFA, 2);
        end
        default: begin
          send(0, $urandom_range(0, 'hF4), 2);
          send(0, 'hFA, 2);
          if ($urandom_range(0, 1) == 1) send(0, 'hF6, 2);
          send(0, $urandom_range(0, 'hF4), 2);
        end
      endcase
      check_model($sformatf("rnd%0d", it));
    end
    check_val("rnd_overrun", 32'(ovr0), 32'd0);

    // Post-reset sweep on dut1
    wait_idle1("t3");
    check_val("t3_own_cycles", 32'(own_cnt1), 32'd3072);
    check_val("t3_own_rises", 32'(own_rise1), 32'd1);
    check_val("t3_last_addr", 32'(last_sweep), 32'h3FF);
    check_val("t3_sweep_bad", 32'(sweep_bad), 32'd0);
    check_val("t3_words", 32'(words1), 32'd0);

    // Two frames during a fresh sweep: first kept, second overruns
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b1;
    send_frame(1, 'h01, 'h02, 'h03, 'h04);
    send_frame(1, 'h05, 'h06, 'h07, 'h08);
    @(negedge clk);
    check_val("t5_busy", 32'(busy1), 32'd1);
    check_val("t5_overrun", 32'(ovr1), 32'd1);
    wait_idle1("t5");
    check_val("t5_nwrites", 32'(obs1_q.size()), 32'd1);
    check_val("t5_addr", 32'(obs1_q.size() > 0 ? obs1_q[0].addr : 10'h3FF), 32'h022);
    check_val("t5_data", 32'(obs1_q.size() > 0 ? obs1_q[0].data : 12'hFFF), 32'h0C4);
    check_val("t5_words", 32'(words1), 32'd1);
    check_val("t5_own_cycles", 32'(own_cnt1), 32'd3075);
    check_val("t5_sweep_bad", 32'(sweep_bad), 32'd0);
    obs1_q.delete();

    // Reset while in W_DL
    send_frame(1, 'h09, 'h0A, 'h0B, 'h0C);
    wait_own1("t6_waddr");
    check_val("t6_waddr_bus", 32'(if1.mem_addr_data), 32'h12A);
    @(posedge clk);
    #1;
    check_val("t6_wdl_bus", 32'({if1.mem_read_write, if1.mem_addr_data}), 32'({1'b1, 10'h00C}));
    commits_before = commits1;
    rst1 = 1'b0;
    #1;
    check_val("t6_rst_ctl", 32'({if1.mem_own, if1.mem_read_write, if1.mem_write_commit,
                                  busy1, ferr1, ovr1, dump1}), 32'd0);
    check_val("t6_rst_bus", 32'(if1.mem_addr_data), 32'd0);
    check_val("t6_rst_words", 32'(words1), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("t6_no_commit", 32'(commits1), 32'(commits_before));
    rst1 = 1'b1;
    wait_own1("t6_sweep");
    check_val("t6_sweep_start", 32'({if1.mem_read_write, if1.mem_write_commit, if1.mem_addr_data}),
              32'({2'b10, 10'h000}));
    wait_idle1("t6");
    check_val("t6_own_cycles", 32'(own_cnt1), 32'd3072);
    check_val("t6_last_addr", 32'(last_sweep), 32'h3FF);
    check_val("t6_sweep_bad", 32'(sweep_bad), 32'd0);
    check_val("t6_nwrites", 32'(obs1_q.size()), 32'd0);
    check_val("t6_words", 32'(words1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
